sc_regscan: RTL
===============

SC_REGSCAN -- requirements
Module: sc_regscan

Interface
REQ-001 Parameter RegSCAN_DATAWIDTH, default 8, SHALL set the bit width of each word read from the register bank.
REQ-002 Parameter RegSCAN_ROWS, default 8, SHALL set the number of words per frame; legal range 2..2^RegSCAN_ADDRWIDTH.
REQ-003 Parameter RegSCAN_ADDRWIDTH, default 3, SHALL set the address bus width.
REQ-004 SC_RegSCAN_CLOCK_50  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 SC_RegSCAN_RESET_InHigh  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 SC_RegSCAN_start_InLow  in  1  SHALL be the active-low frame start request, sampled only in IDLE.
REQ-007 SC_RegSCAN_data_InBUS  in  DATAWIDTH  SHALL be the combinational read data of the external register bank at the current address.
REQ-008 SC_RegSCAN_ready_InHigh  in  1  SHALL indicate that downstream accepts the current serial bit.
REQ-009 SC_RegSCAN_addr_OutBUS  out  ADDRWIDTH  SHALL carry the row address being read.
REQ-010 SC_RegSCAN_serial_Out  out  1  SHALL carry the current bit, MSB first.
REQ-011 SC_RegSCAN_valid_OutHigh  out  1  SHALL mark serial_Out as valid.
REQ-012 SC_RegSCAN_busy_OutHigh  out  1  SHALL be high in every state except IDLE.
REQ-013 SC_RegSCAN_done_OutHigh  out  1  SHALL pulse high for one cycle at the end of a frame.

Function
REQ-014 The FSM SHALL have the states IDLE, FETCH, SHIFT and DONE.
REQ-015 IDLE SHALL go to FETCH with row=0 when start_InLow==0 at a rising edge, and SHALL otherwise hold.
REQ-016 FETCH SHALL last exactly one cycle with addr_OutBUS=row; its closing edge SHALL load data_InBUS into the shift register, clear the bit counter and enter SHIFT.
REQ-017 In SHIFT, valid_OutHigh SHALL be 1 and serial_Out SHALL be the shift register MSB.
REQ-018 A bit SHALL transfer only on an edge where valid&ready==1; the shift register then shifts left and the bit counter increments.
REQ-019 With ready==0, serial_Out, the shift register and the counter SHALL hold, with no timeout.
REQ-020 On the transfer of the last bit of a word: if row==ROWS-1 the FSM SHALL enter DONE; otherwise row SHALL increment and the FSM SHALL enter FETCH.
REQ-021 The word is 1 address cycle plus DATAWIDTH (or DATAWIDTH+1, REQ-029) transfer cycles; there SHALL be no bubbles beyond FETCH.
REQ-022 DONE SHALL last one cycle with done_OutHigh=1, then go to IDLE.
REQ-023 The first valid SHALL appear 2 edges after start is sampled low.
REQ-024 start_InLow SHALL be ignored outside IDLE; if it is still low in IDLE after DONE, a new frame SHALL begin.
REQ-025 addr_OutBUS SHALL hold the last row value outside FETCH/SHIFT, and the row counter SHALL never exceed ROWS-1.

Reset
REQ-026 Reset assertion SHALL immediately force IDLE, row=0, counter=0, shift register=0 and addr_OutBUS=0.
REQ-027 During reset, serial_Out, valid_OutHigh, busy_OutHigh and done_OutHigh SHALL be 0.
REQ-028 Reset mid-frame SHALL abort the frame with no done pulse; after release, the block SHALL wait in IDLE for a new start.

Configuration
REQ-029 When SC_REGSCAN_PARITY_EN is defined, each word SHALL be followed by one extra transferred bit equal to the even parity (XOR) of the captured word, subject to the same valid/ready rules; without the macro, exactly DATAWIDTH bits per word SHALL be sent and no parity logic SHALL exist.

Verification
REQ-030 Defaults, ready=1, bank row r = 8'hA0+r, single start pulse: addresses 0..7; serial stream 10100000, 10100001, ... 10100111; 72 cycles from first FETCH to DONE; exactly one done pulse.
REQ-031 ready toggling 1,0,1,0 during row 0 (8'hA0): each bit is held while ready=0, the stream is unchanged, and the frame length grows by the number of ready=0 SHIFT cycles.
REQ-032 start held low for 3 frames: DONE is followed by IDLE for 1 cycle and then FETCH row 0; busy drops only during that IDLE cycle.
REQ-033 Reset asserted during row 3 bit 4: all outputs are 0 immediately, no done pulse; the next start restarts at addr 0.
REQ-034 SC_REGSCAN_PARITY_EN defined, row word 8'h07: bits 00000111 then parity 1; word 8'h03: parity 0; 9 transfers per row.
REQ-035 start pulsed low during SHIFT: no effect on the stream or the row counter.

Source files
------------

// File: rtl/sc_regscan.sv
// sc_regscan -- frame scanner for an external register bank.
// Walks rows 0..RegSCAN_ROWS-1. Each row costs one FETCH cycle, which presents
// the address and captures the bank word. The word is then sent MSB first over
// a serial valid/ready link.
// Optional feature: define SC_REGSCAN_PARITY_EN to append an even-parity bit
// (XOR of the captured word) after each word.
//
// Handshake: valid_OutHigh is high for every SHIFT cycle. A bit moves on a
// rising edge only when valid and ready are both high. While ready is low,
// serial_Out, the shift register and the bit counter hold, with no timeout.
// The FSM state is exported on SC_RegSCAN_state_OutBUS for observation.
module sc_regscan #(
  parameter int RegSCAN_DATAWIDTH = 8,
  parameter int RegSCAN_ROWS      = 8,
  parameter int RegSCAN_ADDRWIDTH = 3
) (
  input  logic                         SC_RegSCAN_CLOCK_50,
  input  logic                         SC_RegSCAN_RESET_InHigh,
  input  logic                         SC_RegSCAN_start_InLow,
  input  logic [RegSCAN_DATAWIDTH-1:0] SC_RegSCAN_data_InBUS,
  input  logic                         SC_RegSCAN_ready_InHigh,
  output logic [RegSCAN_ADDRWIDTH-1:0] SC_RegSCAN_addr_OutBUS,
  output logic                         SC_RegSCAN_serial_Out,
  output logic                         SC_RegSCAN_valid_OutHigh,
  output logic                         SC_RegSCAN_busy_OutHigh,
  output logic                         SC_RegSCAN_done_OutHigh,
  output logic [1:0]                   SC_RegSCAN_state_OutBUS
);

`ifdef SC_REGSCAN_PARITY_EN
  localparam int WORD_BITS = RegSCAN_DATAWIDTH + 1;
`else
  localparam int WORD_BITS = RegSCAN_DATAWIDTH;
`endif
  localparam int CNT_W = $clog2(WORD_BITS + 1);
  localparam logic [RegSCAN_ADDRWIDTH-1:0] LAST_ROW = RegSCAN_ADDRWIDTH'(RegSCAN_ROWS - 1);
  localparam logic [CNT_W-1:0]             LAST_BIT = CNT_W'(WORD_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                         state, stateNext;
  logic [RegSCAN_ADDRWIDTH-1:0]   row, rowNext;
  logic [WORD_BITS-1:0]           shiftReg, shiftNext;
  logic [CNT_W-1:0]               bitCnt, bitCntNext;
  logic [WORD_BITS-1:0]           captureWord;
  logic                           xfer;

  // Word captured at the end of FETCH, with the parity bit appended when enabled
`ifdef SC_REGSCAN_PARITY_EN
  assign captureWord = {SC_RegSCAN_data_InBUS, ^SC_RegSCAN_data_InBUS};
`else
  assign captureWord = SC_RegSCAN_data_InBUS;
`endif

  assign xfer = (state == ST_SHIFT) && SC_RegSCAN_ready_InHigh;

  // State, row, shift register and bit counter; reset clears all of them at once
  always_ff @(posedge SC_RegSCAN_CLOCK_50 or posedge SC_RegSCAN_RESET_InHigh) begin
    if (SC_RegSCAN_RESET_InHigh) begin
      state    <= ST_IDLE;
      row      <= '0;
      shiftReg <= '0;
      bitCnt   <= '0;
    end else begin
      state    <= stateNext;
      row      <= rowNext;
      shiftReg <= shiftNext;
      bitCnt   <= bitCntNext;
    end
  end

  // Next-state logic; everything holds unless a transition says otherwise
  always_comb begin
    stateNext  = state;
    rowNext    = row;
    shiftNext  = shiftReg;
    bitCntNext = bitCnt;
    case (state)
      ST_IDLE: begin
        if (!SC_RegSCAN_start_InLow) begin
          stateNext = ST_FETCH;
          rowNext   = '0;
        end
      end
      ST_FETCH: begin
        shiftNext  = captureWord;
        bitCntNext = '0;
        stateNext  = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (xfer) begin
          shiftNext  = shiftReg << 1;
          bitCntNext = bitCnt + CNT_W'(1);
          if (bitCnt == LAST_BIT) begin
            if (row == LAST_ROW) begin
              stateNext = ST_DONE;
            end else begin
              rowNext   = row + RegSCAN_ADDRWIDTH'(1);
              stateNext = ST_FETCH;
            end
          end
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
      end
      default: begin
        stateNext = ST_IDLE;
      end
    endcase
  end

  // The address is the row register itself, so it keeps the last row outside a frame
  assign SC_RegSCAN_addr_OutBUS   = row;
  assign SC_RegSCAN_valid_OutHigh = (state == ST_SHIFT);
  assign SC_RegSCAN_serial_Out    = (state == ST_SHIFT) && shiftReg[WORD_BITS-1];
  assign SC_RegSCAN_busy_OutHigh  = (state != ST_IDLE);
  assign SC_RegSCAN_done_OutHigh  = (state == ST_DONE);
  assign SC_RegSCAN_state_OutBUS  = state;

endmodule
